sdf_twiddle_sequencer: RTL and testbench
========================================

Name: sdf_twiddle_sequencer

Overview:
Address sequencer for the twiddle-factor ROM in the radix-2^2 SDF FFT pipeline. One instance sits in front of each inter-stage complex multiplier. It counts accepted samples within a frame and generates the ROM address (twiddle exponent) for each sample. It also produces a valid/start-of-frame pair that is delay-matched to the ROM read latency, so the multiplier sees each sample and its twiddle on the same cycle.

Parameters:
LOG_N, 6, log2 of full FFT size; ROM depth is 2^LOG_N and address width is LOG_N
M, 6, log2 of the sub-FFT span served by this multiplier (legal: even, 4..LOG_N)
ROM_LAT, 1, ROM read latency in cycles from registered address to twiddle data (legal 1..4)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample accepted this cycle
in_sof  in  1  first sample of a frame; qualified by in_valid
rom_en  out  1  ROM read enable, high when rom_addr is new
rom_addr  out  LOG_N  twiddle ROM address
out_valid  out  1  twiddle data valid at ROM output this cycle
out_sof  out  1  out_valid cycle belongs to sample with in_sof
busy  out  1  frame in progress or pipeline not drained
sync_err  out  1  one-cycle pulse on framing violation

Behaviour:
- Reset (async assert, sync release): cnt=0, state=IDLE. rom_en, rom_addr, out_valid, out_sof, busy and sync_err are all 0. Delay line is cleared.
- Counter cnt is M bits. It advances only on accepted samples (in_valid=1). Gaps in in_valid hold cnt and all addressing state.
- Exponent per accepted sample with counter value c:
  - f = c[M-1] + 2*c[M-2], range 0..3.
  - e = f * c[M-3:0].
  - rom_addr = e << (LOG_N-M).
  - Maximum is 3*(2^(M-2)-1)*2^(LOG_N-M), which is always < 2^LOG_N. No wrap or truncation is permitted; an assertion checks this.
- Timing:
  - rom_addr and rom_en are registered on the edge that accepts the sample.
  - rom_en is high for exactly one cycle per accepted sample; rom_addr holds its last value otherwise.
  - out_valid and out_sof are rom_en and the registered sof, delayed by ROM_LAT further cycles.
  - Total latency from in_valid accept to out_valid is 1+ROM_LAT cycles.
- State machine:
  - IDLE:
    - in_valid & in_sof: accept with c=0, set cnt=1, go to RUN.
    - in_valid & !in_sof: drop the sample (no rom_en), pulse sync_err, stay IDLE.
  - RUN:
    - in_valid & !in_sof: accept with c=cnt, cnt=cnt+1 (mod 2^M). The wrap from 2^M-1 to 0 keeps RUN, so back-to-back frames stream.
    - in_valid & in_sof when cnt==0: normal frame start.
    - in_valid & in_sof when cnt!=0: resync. Accept with c=0, set cnt=1, pulse sync_err.
  - Drain to IDLE: no in_valid for 2^M consecutive cycles while cnt==0 returns to IDLE.
- busy = (state==RUN) OR any delay-line stage holding a valid.
- Simultaneous events: the in_sof resync rule takes precedence over the counter wrap.
- Reset mid-frame: all outputs go to 0 immediately. The delay line is flushed, so no out_valid appears after reset release. The next frame requires in_sof.

Test Plan:
- LOG_N=6, M=6, ROM_LAT=1; in_sof+in_valid then 63 back-to-back valids -> rom_addr sequence:
  - c 0..15: 0.
  - c 16..31: 0,2,...,30.
  - c 32..47: 0,1,...,15.
  - c 48..63: 0,3,...,45.
  - out_valid first asserted 2 cycles after the sof accept; out_sof coincides.
- Same frame with in_valid low on every other cycle -> identical rom_addr sequence; rom_en is one pulse per valid; cnt holds during gaps.
- M=4, LOG_N=6, continuous valid for two frames with sof only on the first -> each 16-sample period is:
  - 0,0,0,0
  - 0,8,16,24
  - 0,4,8,12
  - 0,12,24,36
  - The second frame repeats this with no sync_err.
- in_valid without in_sof from IDLE -> no rom_en, sync_err one pulse; a following sof starts at rom_addr 0.
- in_sof at c=20 mid-frame (M=6) -> sync_err pulse; that sample gets rom_addr 0 and the next gets 0 (c=1); out_sof follows 1+ROM_LAT cycles later.
- ROM_LAT=3, rst_n low at c=40 -> all outputs 0 immediately; no out_valid after release; busy=0 until the next sof.

Source files
------------

// File: rtl/sdf_twiddle_sequencer.sv
// Twiddle ROM address sequencer for one radix-2^2 SDF multiplier stage.
// Counts accepted samples per frame and emits the ROM address plus a latency-matched valid/sof pair.
module sdf_twiddle_sequencer #(
  parameter int LOG_N   = 6,
  parameter int M       = 6,
  parameter int ROM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             rom_en,
  output logic [LOG_N-1:0] rom_addr,
  output logic             out_valid,
  output logic             out_sof,
  output logic             busy,
  output logic             sync_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [M-1:0]       cnt_q, cnt_d;
  logic [M-1:0]       quiet_q, quiet_d;
  logic               accept;
  logic               restart;
  logic               err_d;
  logic [M-1:0]       c_sel;
  logic [1:0]         f;
  logic [M+1:0]       e;
  logic [LOG_N+1:0]   addr_wide;
  logic               rom_en_q;
  logic [LOG_N-1:0]   rom_addr_q, rom_addr_d;
  logic               sof_q;
  logic               sync_err_q;
  logic [ROM_LAT-1:0] pipe_v_q, pipe_v_d;
  logic [ROM_LAT-1:0] pipe_s_q, pipe_s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // quiet_q counts earlier idle cycles at cnt==0; this cycle is the 2^M-th when it is all ones
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid && in_sof) state_d = RUN;
      RUN:  if (!in_valid && (cnt_q == '0) && (quiet_q == '1)) state_d = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    restart = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_sof) begin
            accept  = 1'b1;
            restart = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (in_valid) begin
          accept = 1'b1;
          if (in_sof) begin
            restart = 1'b1;
            err_d   = (cnt_q != '0);
          end
        end
      end
    endcase
  end

  // The sof resync forces c=0 regardless of where the counter was, overriding any wrap
  always_comb begin
    c_sel     = restart ? '0 : cnt_q;
    cnt_d     = accept ? c_sel + 1'b1 : cnt_q;
    quiet_d   = ((state_q == RUN) && !in_valid && (cnt_q == '0)) ? quiet_q + 1'b1 : '0;
    f         = {c_sel[M-2], c_sel[M-1]};
    e         = (M+2)'(f) * (M+2)'(c_sel[M-3:0]);
    addr_wide = (LOG_N+2)'(e) << (LOG_N - M);
    rom_addr_d = accept ? addr_wide[LOG_N-1:0] : rom_addr_q;
  end

  for (genvar gi = 0; gi < ROM_LAT; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      assign pipe_v_d[gi] = rom_en_q;
      assign pipe_s_d[gi] = sof_q;
    end else begin : g_tail
      assign pipe_v_d[gi] = pipe_v_q[gi-1];
      assign pipe_s_d[gi] = pipe_s_q[gi-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      quiet_q    <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      sof_q      <= 1'b0;
      sync_err_q <= 1'b0;
      pipe_v_q   <= '0;
      pipe_s_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      quiet_q    <= quiet_d;
      rom_en_q   <= accept;
      rom_addr_q <= rom_addr_d;
      sof_q      <= accept & in_sof;
      sync_err_q <= err_d;
      pipe_v_q   <= pipe_v_d;
      pipe_s_q   <= pipe_s_d;
    end
  end

  always @(posedge clk) begin
    if (rst_n && accept) begin
      assert (addr_wide < ((LOG_N+2)'(1) << LOG_N));
    end
  end

  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign out_valid = pipe_v_q[ROM_LAT-1];
  assign out_sof   = pipe_s_q[ROM_LAT-1];
  assign sync_err  = sync_err_q;
  assign busy      = (state_q == RUN) | rom_en_q | (|pipe_v_q);

endmodule

// File: tb/tb_sdf_twiddle_sequencer.sv
// Bench for sdf_twiddle_sequencer: three parameter sets driven against a frame-position reference model.
module tb_sdf_twiddle_sequencer;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] iv;
  logic [2:0] is;
  logic [2:0] ren, ov, os, bsy, serr;
  logic [2:0][5:0] addr;

  int checks = 0;
  int errors = 0;

  // Reference state: pos = -1 idle, otherwise position within frame of the next sample
  int       pos[3];
  int       quiet[3];
  bit       ehv[3][8];
  bit       ehs[3][8];
  bit [5:0] exp_addr[3];
  bit       exp_err[3];

  always #5 clk = ~clk;

  sdf_twiddle_sequencer #(.LOG_N(6), .M(6), .ROM_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(iv[0]), .in_sof(is[0]),
    .rom_en(ren[0]), .rom_addr(addr[0]), .out_valid(ov[0]), .out_sof(os[0]),
    .busy(bsy[0]), .sync_err(serr[0]));
  sdf_twiddle_sequencer #(.LOG_N(6), .M(4), .ROM_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(iv[1]), .in_sof(is[1]),
    .rom_en(ren[1]), .rom_addr(addr[1]), .out_valid(ov[1]), .out_sof(os[1]),
    .busy(bsy[1]), .sync_err(serr[1]));
  sdf_twiddle_sequencer #(.LOG_N(6), .M(6), .ROM_LAT(3)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .in_valid(iv[2]), .in_sof(is[2]),
    .rom_en(ren[2]), .rom_addr(addr[2]), .out_valid(ov[2]), .out_sof(os[2]),
    .busy(bsy[2]), .sync_err(serr[2]));

  function automatic int mval(input int x);
    return (x == 1) ? 4 : 6;
  endfunction

  function automatic int lat(input int x);
    return (x == 2) ? 3 : 1;
  endfunction

  // Twiddle exponent scaled to the full ROM: f picks the radix-2^2 quadrant, times the low bits
  function automatic bit [5:0] twid(input int c, input int m);
    int fq;
    fq = ((c >> (m - 1)) & 1) + 2 * ((c >> (m - 2)) & 1);
    return 6'(fq * (c % (1 << (m - 2))) * (1 << (6 - m)));
  endfunction

  task automatic model_reset(input int x);
    pos[x] = -1;
    quiet[x] = 0;
    exp_addr[x] = '0;
    exp_err[x] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ehv[x][k] = 1'b0;
      ehs[x][k] = 1'b0;
    end
  endtask

  task automatic model_edge(input int x, input bit v, input bit s);
    int  m;
    int  c;
    bit  acc;
    if (!rst_n[x]) begin
      model_reset(x);
      return;
    end
    m = mval(x);
    acc = 1'b0;
    c = 0;
    for (int k = 7; k > 0; k--) begin
      ehv[x][k] = ehv[x][k-1];
      ehs[x][k] = ehs[x][k-1];
    end
    ehv[x][0] = 1'b0;
    ehs[x][0] = 1'b0;
    exp_err[x] = 1'b0;
    if (v) begin
      quiet[x] = 0;
      if (pos[x] < 0) begin
        if (s) begin
          acc = 1'b1;
          pos[x] = 1;
        end else begin
          exp_err[x] = 1'b1;
        end
      end else if (s) begin
        exp_err[x] = (pos[x] != 0);
        acc = 1'b1;
        pos[x] = 1;
      end else begin
        acc = 1'b1;
        c = pos[x];
        pos[x] = (pos[x] + 1) % (1 << m);
      end
      if (acc) begin
        ehv[x][0] = 1'b1;
        ehs[x][0] = s;
        exp_addr[x] = twid(c, m);
      end
    end else if (pos[x] == 0) begin
      quiet[x]++;
      if (quiet[x] == (1 << m)) begin
        pos[x] = -1;
        quiet[x] = 0;
      end
    end else begin
      quiet[x] = 0;
    end
  endtask

  // Packed {rom_en, rom_addr, out_valid, out_sof, sync_err, busy}
  function automatic logic [10:0] exp_vec(input int x);
    bit b;
    b = (pos[x] >= 0);
    for (int k = 0; k <= lat(x); k++) b = b | ehv[x][k];
    return {ehv[x][0], exp_addr[x], ehv[x][lat(x)], ehs[x][lat(x)], exp_err[x], b};
  endfunction

  function automatic logic [10:0] obs_vec(input int x);
    return {ren[x], addr[x], ov[x], os[x], serr[x], bsy[x]};
  endfunction

  // d==3 idles every instance for one cycle
  task automatic step(input int d, input bit v, input bit s);
    @(negedge clk);
    for (int x = 0; x < 3; x++) begin
      iv[x] = (x == d) ? v : 1'b0;
      is[x] = (x == d) ? s : 1'b0;
      model_edge(x, (x == d) && v, (x == d) && s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int x = 0; x < 3; x++) begin
      if (obs_vec(x) !== 11'd0) begin
        errors++;
        $display("FAIL reset dut%0d got %b expected %b", x, obs_vec(x), 11'd0);
      end
      checks++;
    end
    @(negedge clk);
    rst_n = 3'b111;
  endtask

  task automatic test_frame();
    for (int i = 0; i < 64; i++) begin
      step(0, 1'b1, i == 0);
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL frame i=%0d got %b expected %b", i, obs_vec(0), exp_vec(0));
      end
      checks++;
      if (i == 1 && !(ov[0] === 1'b1 && os[0] === 1'b1)) begin
        errors++;
        $display("FAIL frame_latency ov=%b os=%b expected 1 1", ov[0], os[0]);
      end
      if (i == 1) checks++;
      if (i == 50 && addr[0] !== 6'd6) begin
        errors++;
        $display("FAIL frame_c50 addr=%0d expected 6", addr[0]);
      end
      if (i == 50) checks++;
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 64; i++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int k = 0; k < g; k++) begin
        step(0, 1'b0, 1'b0);
        if (obs_vec(0) !== exp_vec(0)) begin
          errors++;
          $display("FAIL gaps_idle i=%0d got %b expected %b", i, obs_vec(0), exp_vec(0));
        end
        checks++;
      end
      step(0, 1'b1, i == 0);
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL gaps i=%0d got %b expected %b", i, obs_vec(0), exp_vec(0));
      end
      checks++;
    end
  endtask

  task automatic test_drain_idle_err();
    for (int i = 0; i < 70; i++) begin
      step(3, 1'b0, 1'b0);
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL drain i=%0d got %b expected %b", i, obs_vec(0), exp_vec(0));
      end
      checks++;
    end
    if (bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL drain_busy got %b expected 0", bsy[0]);
    end
    checks++;
    step(0, 1'b1, 1'b0);
    if (!(serr[0] === 1'b1 && ren[0] === 1'b0)) begin
      errors++;
      $display("FAIL idle_drop serr=%b ren=%b expected 1 0", serr[0], ren[0]);
    end
    checks++;
    step(0, 1'b0, 1'b0);
    if (obs_vec(0) !== exp_vec(0)) begin
      errors++;
      $display("FAIL idle_after got %b expected %b", obs_vec(0), exp_vec(0));
    end
    checks++;
  endtask

  task automatic test_resync();
    for (int i = 0; i < 26; i++) begin
      step(0, 1'b1, (i == 0) || (i == 20));
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL resync i=%0d got %b expected %b", i, obs_vec(0), exp_vec(0));
      end
      checks++;
      if (i == 20 && !(serr[0] === 1'b1 && addr[0] === 6'd0)) begin
        errors++;
        $display("FAIL resync_pulse serr=%b addr=%0d expected 1 0", serr[0], addr[0]);
      end
      if (i == 20) checks++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) begin
      step(1, 1'b1, i == 0);
      if (obs_vec(1) !== exp_vec(1)) begin
        errors++;
        $display("FAIL b2b i=%0d got %b expected %b", i, obs_vec(1), exp_vec(1));
      end
      checks++;
      if ((i == 6 || i == 22) && addr[1] !== 6'd16) begin
        errors++;
        $display("FAIL b2b_c6 i=%0d addr=%0d expected 16", i, addr[1]);
      end
      if (i == 6 || i == 22) checks++;
    end
  endtask

  task automatic test_random();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 250; i++) begin
        bit v;
        bit s;
        v = ($urandom_range(0, 9) < 7);
        s = ($urandom_range(0, 39) == 0) || (!v && $urandom_range(0, 1) == 1);
        step(d, v, s);
        if (obs_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL random dut%0d i=%0d got %b expected %b", d, i, obs_vec(d), exp_vec(d));
        end
        checks++;
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 41; i++) step(2, 1'b1, i == 0);
    if (ren[2] !== 1'b1) begin
      errors++;
      $display("FAIL mid_prerun ren=%b expected 1", ren[2]);
    end
    checks++;
    rst_n[2] = 1'b0;
    model_reset(2);
    #1;
    if (obs_vec(2) !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset got %b expected %b", obs_vec(2), 11'd0);
    end
    checks++;
    step(3, 1'b0, 1'b0);
    step(3, 1'b0, 1'b0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(3, 1'b0, 1'b0);
      if (ov[2] !== 1'b0 || bsy[2] !== 1'b0 || obs_vec(2) !== exp_vec(2)) begin
        errors++;
        $display("FAIL mid_after i=%0d got %b expected %b", i, obs_vec(2), exp_vec(2));
      end
      checks++;
    end
    for (int i = 0; i < 6; i++) begin
      step(2, 1'b1, i == 0);
      if (obs_vec(2) !== exp_vec(2)) begin
        errors++;
        $display("FAIL mid_restart i=%0d got %b expected %b", i, obs_vec(2), exp_vec(2));
      end
      checks++;
    end
  endtask

  initial begin
    rst_n = 3'b000;
    iv = '0;
    is = '0;
    for (int x = 0; x < 3; x++) model_reset(x);
    test_reset();
    test_frame();
    test_gaps();
    test_drain_idle_err();
    test_resync();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
